mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en sampled to mem_rdata valid; legal range 1..8.
- STARVE_MAX, 4, consecutive dm grants with if_req pending before if is forced.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; low at a rising edge resets the block.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data, valid while if_ack=1.
- if_ack  out  1  fetch complete, one-cycle pulse.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  store byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1.
- dm_ack  out  1  data complete, one-cycle pulse.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; transitions SHALL be:
- IDLE -> ISSUE when any request is pending.
- ISSUE -> WAIT after exactly one cycle.
- WAIT -> RESP after MEM_LAT cycles.
- RESP -> IDLE after exactly one cycle.

REQ-004 Grant SHALL be decided in IDLE. Address, we, be and wdata of the winner SHALL be latched at that edge; later requester changes SHALL be ignored until RESP.

REQ-005 Priority SHALL go to dm over if, unless the starvation counter equals STARVE_MAX and if_req=1; in that case if SHALL win.

REQ-006 The starvation counter SHALL behave as follows:
- Increment on each dm grant made while if_req=1, saturating at STARVE_MAX.
- Clear on any if grant.
- Clear on any dm grant made while if_req=0.

REQ-007 In ISSUE, mem outputs SHALL be driven as follows:
- mem_en=1.
- mem_addr = latched address.
- Fetch: mem_we=0, mem_be=4'b1111.
- Load: mem_we=0, mem_be=4'b1111.
- Store: mem_we=1, mem_be=dm_be, mem_wdata=dm_wdata.
In all other states mem_en=0 and mem_we=0.

REQ-008 mem_rdata SHALL be captured in the last WAIT cycle and presented on the granted port's rdata during RESP. Stores SHALL present rdata=0.

REQ-009 In RESP, exactly one of if_ack/dm_ack SHALL be 1 for one cycle, selecting the granted port. Ack SHALL occur MEM_LAT+2 cycles after the IDLE grant cycle (MEM_LAT=1: grant T, ack T+3).

REQ-010 No grant SHALL be made in RESP. A request still held high in the ack cycle SHALL be treated as a new request in the following IDLE cycle.

REQ-011 A requester that drops req before ack SHALL NOT abort the access; the ack SHALL still be pulsed.

REQ-012 Both requests arriving in the same IDLE cycle SHALL be resolved per REQ-005; the loser's stall SHALL remain high throughout.

REQ-013 if_stall and dm_stall SHALL be combinational from req and ack. All other outputs SHALL be registered.

Reset
REQ-014 On reset=0 at a rising edge, the block SHALL:
- enter IDLE;
- clear the starvation counter;
- drive mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata and dm_rdata to 0.

REQ-015 Reset mid-access (ISSUE, WAIT or RESP) SHALL abort the access with no ack emitted. No mem_en SHALL appear in the cycle following the reset edge.

Structure
REQ-016 The shared package rv32i_pkg SHALL hold the BE_ALL (4'b1111) constant and the MEM_LAT default. State encoding SHALL stay local to the module.

REQ-017 No sub-module is required. The starvation counter and FSM SHALL reside in mem_port_arbiter.

Verification
REQ-018 Fetch only: if_req=1, if_addr=0x0000_0010, mem returns 0x0000_0513 -> mem_en pulses at T+1 with addr 0x10, if_ack=1 at T+3, if_rdata=0x0000_0513.

REQ-019 Simultaneous if_req and dm_req (load, addr 0x100) -> dm granted first, dm_ack at T+3. if is granted at T+4 and if_ack occurs at T+7; if_stall stays high from T to T+6.

REQ-020 Store: dm_we=1, dm_be=4'b0011, dm_wdata=0xDEAD_BEEF, addr 0x200 -> single mem_en with mem_we=1, mem_be=0011, wdata 0xDEADBEEF; dm_ack at T+3, dm_rdata=0.

REQ-021 Starvation: dm_req and if_req held high continuously -> four dm grants, then one if grant, then dm resumes.

REQ-022 Reset mid-access: reset=0 during WAIT -> no ack; all outputs 0 next cycle; a fresh if request after release gives ack at MEM_LAT+2.

REQ-023 MEM_LAT=3 build, fetch only -> if_ack 5 cycles after grant.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants for the memory-side blocks of the core.
package rv32i_pkg;

  localparam logic [3:0]  BE_ALL          = 4'b1111;
  localparam int unsigned MEM_LAT_DEFAULT = 1;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-outstanding memory port,
// with dm priority and a starvation guard that eventually forces a fetch through.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  port_e              gnt_q,       gnt_d;
  logic               we_q,        we_d;
  logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
  logic [STV_W-1:0]   starve_q,    starve_d;
  logic               mem_en_q,    mem_en_d;
  logic               mem_we_q,    mem_we_d;
  logic [3:0]         mem_be_q,    mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               if_ack_q,    if_ack_d;
  logic               dm_ack_q,    dm_ack_d;
  logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]  dm_rdata_q,  dm_rdata_d;
  logic               dm_wins;

  // dm normally wins; a saturated counter hands one grant to a waiting fetch.
  assign dm_wins = dm_req && !(if_req && (starve_q == STV_LIMIT));

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (dm_wins) begin
            gnt_d       = PORT_DM;
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_be_d    = dm_we ? dm_be : BE_ALL;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_we ? dm_wdata : '0;
            if (!if_req)                 starve_d = '0;
            else if (starve_q != STV_LIMIT) starve_d = starve_q + 1'b1;
          end else begin
            gnt_d      = PORT_IF;
            we_d       = 1'b0;
            mem_be_d   = BE_ALL;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = '0;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (gnt_q == PORT_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= PORT_IF;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected accesses checked by
// a monitor, plus a MEM_LAT=3 instance for latency.
module tb_mem_port_arbiter;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          pushes = 0;
  int          mem_en_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with default latency
  logic        if_req, if_ack, if_stall, dm_req, dm_we, dm_ack, dm_stall, mem_en, mem_we;
  logic [3:0]  dm_be, mem_be;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  // DUT with MEM_LAT=3, fetch only
  logic        if_req3, if_ack3, if_stall3, dm_ack3, dm_stall3, mem_en3, mem_we3;
  logic [3:0]  mem_be3;
  logic [31:0] if_addr3, if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3), .if_stall(if_stall3),
    .dm_req(1'b0), .dm_we(1'b0), .dm_be(4'h0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_rdata(dm_rdata3), .dm_ack(dm_ack3), .dm_stall(dm_stall3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_0513;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory models: read data valid for exactly one cycle, MEM_LAT edges after mem_en.
  logic        mvld0;
  logic [31:0] mdat0;
  logic        mvld3 [3];
  logic [31:0] mdat3 [3];

  always @(posedge clk) begin
    if (!reset) begin
      mvld0 <= 1'b0;
      for (int i = 0; i < 3; i++) mvld3[i] <= 1'b0;
    end else begin
      mvld0    <= mem_en & ~mem_we;
      mdat0    <= mem_fn(mem_addr);
      mvld3[0] <= mem_en3 & ~mem_we3;
      mdat3[0] <= mem_fn(mem_addr3);
      for (int i = 1; i < 3; i++) begin
        mvld3[i] <= mvld3[i-1];
        mdat3[i] <= mdat3[i-1];
      end
    end
  end

  assign mem_rdata  = mvld0    ? mdat0    : BAD;
  assign mem_rdata3 = mvld3[2] ? mdat3[2] : BAD;

  typedef struct {
    logic        is_dm;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push(input logic is_dm, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata, input int ack_cyc);
    exp_t e;
    e.is_dm   = is_dm;
    e.addr    = addr;
    e.we      = we;
    e.be      = be;
    e.wdata   = wdata;
    e.rdata   = we ? 32'h0 : mem_fn(addr);
    e.ack_cyc = ack_cyc;
    sb.push_back(e);
    pushes++;
  endfunction

  // Monitor: mem strobe compared against the in-flight entry, ack pops it.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mem_en) begin
        mem_en_cnt++;
        check("mem_en_expected", 96'(sb.size() != 0), 96'(1));
        if (sb.size() != 0) begin
          check("mem_en_cycle", 96'(cyc), 96'(sb[0].ack_cyc - 2));
          check("mem_addr",  mem_addr,  sb[0].addr);
          check("mem_we",    mem_we,    sb[0].we);
          check("mem_be",    mem_be,    sb[0].be);
          check("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (if_ack || dm_ack) begin
        check("ack_onehot", {if_ack, dm_ack} == 2'b11, 1'b0);
        check("ack_expected", 96'(sb.size() != 0), 96'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port",  dm_ack, e.is_dm);
          check("ack_cycle", 96'(cyc), 96'(e.ack_cyc));
          check("ack_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_ack(input logic want_dm, input int budget);
    int n = 0;
    while (!(want_dm ? dm_ack : if_ack) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(want_dm ? "dm_ack_seen" : "if_ack_seen", want_dm ? dm_ack : if_ack, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bit seen;
    reset = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    if_req3 = 0; if_addr3 = 0;
    repeat (3) @(negedge clk);

    check("rst_mem",   {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check("rst_ack",   {if_ack, dm_ack, if_ack3, dm_ack3}, '0);
    check("rst_rdata", {if_rdata, dm_rdata}, '0);
    check("rst_stall", {if_stall, dm_stall}, '0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_en", mem_en, 1'b0);

    // Fetch, request held through the ack cycle
    @(negedge clk);
    t = cyc;
    if_req = 1; if_addr = 32'h10;
    push(0, 32'h10, 0, 4'hF, 32'h0, t + 3);
    #1 check("fetch_stall", if_stall, 1'b1);
    wait_ack(0, 8);
    check("fetch_rdata", if_rdata, 32'h0000_0513);
    check("fetch_stall_ack", if_stall, 1'b0);
    if_req = 0;

    // Fetch dropped after one cycle still completes; address change ignored
    @(negedge clk);
    t = cyc;
    if_req = 1; if_addr = 32'h24;
    push(0, 32'h24, 0, 4'hF, 32'h0, t + 3);
    @(negedge clk);
    if_req = 0; if_addr = 32'hFFF0;
    wait_ack(0, 8);

    // Store with changing inputs after grant
    @(negedge clk);
    t = cyc;
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h200;
    push(1, 32'h200, 1, 4'b0011, 32'hDEAD_BEEF, t + 3);
    @(negedge clk);
    dm_addr = 32'h999; dm_wdata = 32'h0; dm_be = 4'hF; dm_we = 0;
    wait_ack(1, 8);
    check("store_rdata", dm_rdata, 32'h0);
    dm_req = 0;

    // Load: byte enables forced to all-ones
    @(negedge clk);
    t = cyc;
    dm_req = 1; dm_we = 0; dm_be = 4'b0101; dm_addr = 32'h300;
    push(1, 32'h300, 0, 4'hF, 32'h0, t + 3);
    wait_ack(1, 8);
    dm_req = 0;

    // Simultaneous requests: dm first, if waits with stall high
    @(negedge clk);
    t = cyc;
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    push(1, 32'h100, 0, 4'hF, 32'h0, t + 3);
    push(0, 32'h40,  0, 4'hF, 32'h0, t + 7);
    for (int k = 0; k < 7; k++) begin
      #1;
      check("sim_if_stall", if_stall, 1'b1);
      check("sim_dm_stall", dm_stall, k < 3);
      if (k == 3) dm_req = 0;
      @(negedge clk);
    end
    check("sim_if_ack", if_ack, 1'b1);
    check("sim_if_stall_ack", if_stall, 1'b0);
    if_req = 0;

    // Starvation: four dm grants, one forced fetch, then dm again
    @(negedge clk);
    t = cyc;
    if_req = 1; if_addr = 32'h50;
    dm_req = 1; dm_we = 0; dm_addr = 32'h180;
    for (int g = 0; g < 4; g++) push(1, 32'h180, 0, 4'hF, 32'h0, t + 3 + 4 * g);
    push(0, 32'h50,  0, 4'hF, 32'h0, t + 19);
    push(1, 32'h180, 0, 4'hF, 32'h0, t + 23);
    while (cyc < t + 23) @(negedge clk);
    check("starve_last_dm", dm_ack, 1'b1);
    if_req = 0; dm_req = 0;

    // Reset during WAIT aborts the access
    @(negedge clk);
    t = cyc;
    if_req = 1; if_addr = 32'h80;
    push(0, 32'h80, 0, 4'hF, 32'h0, t + 3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    check("abort_mem", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check("abort_ack", {if_ack, dm_ack}, '0);
    check("abort_rdata", {if_rdata, dm_rdata}, '0);
    reset = 1'b1;
    if_req = 0;
    @(negedge clk);
    check("post_rst_no_en", mem_en, 1'b0);
    check("post_rst_no_ack", if_ack, 1'b0);
    t = cyc;
    if_req = 1; if_addr = 32'h84;
    push(0, 32'h84, 0, 4'hF, 32'h0, t + 3);
    wait_ack(0, 8);
    if_req = 0;

    // MEM_LAT=3 instance: ack five cycles after grant
    @(negedge clk);
    t = cyc;
    seen = 0;
    if_req3 = 1; if_addr3 = 32'h10;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      if (mem_en3) begin
        check("lat3_en_cycle", 96'(cyc), 96'(t + 1));
        check("lat3_addr", mem_addr3, 32'h10);
      end
      if (if_ack3) begin
        seen = 1;
        check("lat3_ack_cycle", 96'(cyc), 96'(t + 5));
        check("lat3_rdata", if_rdata3, 32'h0000_0513);
        if_req3 = 0;
      end
    end
    check("lat3_ack_seen", seen, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drained", 96'(sb.size()), 96'(0));
    check("mem_en_count", 96'(mem_en_cnt), 96'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
